// File: rtl/shift_left_pkg.sv
// Shared constants for the shift_left registered barrel shifter.
package shift_left_pkg;

   localparam int DATA_W  = 32;
   localparam int SHAMT_W = 32;
   localparam int STAGES  = $clog2(DATA_W);

   // A 1-bit datapath still needs one stage so the generate loop is never empty.
   function automatic int stage_count(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/shl_barrel_stage.sv
// One barrel stage: optional left shift by the constant SHIFT, plus a flag
// that is set when a nonzero bit falls off the top.
module shl_barrel_stage #(
   parameter int WIDTH = 32,
   parameter int SHIFT = 1
) (
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             lost
);

   generate
      if (SHIFT >= WIDTH) begin : g_full
         assign dout = en ? '0 : din;
         assign lost = en & (|din);
      end else begin : g_part
         assign dout = en ? (din << SHIFT) : din;
         assign lost = en & (|din[WIDTH-1 -: SHIFT]);
      end
   endgenerate

endmodule

// File: rtl/shift_left.sv
// Registered logical left shifter with one-cycle latency.
// Define SHIFT_LEFT_OVF_EN to add the registered ovf (bits lost) output.
module shift_left
   import shift_left_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   A,
   input  logic [SHAMT_W-1:0] B,
   output logic               out_valid,
`ifdef SHIFT_LEFT_OVF_EN
   output logic [WIDTH-1:0]   out,
   output logic               ovf
`else
   output logic [WIDTH-1:0]   out
`endif
);

   localparam int NSTAGE = stage_count(WIDTH);

   logic [WIDTH-1:0] stage_data [0:NSTAGE];
   logic [NSTAGE-1:0] stage_lost;
   logic             high_set;
   logic [WIDTH-1:0] shifted;

   assign stage_data[0] = A;

   generate
      for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
         shl_barrel_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << k)
         ) u_stage (
            .en   (B[k]),
            .din  (stage_data[k]),
            .dout (stage_data[k+1]),
            .lost (stage_lost[k])
         );
      end
   endgenerate

   // Shift amounts beyond the stage range flush everything; never wrap modulo WIDTH.
   assign high_set = |B[SHAMT_W-1:NSTAGE];
   assign shifted  = high_set ? '0 : stage_data[NSTAGE];

`ifdef SHIFT_LEFT_OVF_EN
   logic ovf_next;
   assign ovf_next = high_set ? (|A) : (|stage_lost);
`else
   logic unused_lost;
   assign unused_lost = |stage_lost;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out       <= '0;
`ifdef SHIFT_LEFT_OVF_EN
         ovf       <= 1'b0;
`endif
      end else if (in_valid) begin
         out_valid <= 1'b1;
         out       <= shifted;
`ifdef SHIFT_LEFT_OVF_EN
         ovf       <= ovf_next;
`endif
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shift_left.sv
// Self-checking bench for shift_left: directed steps plus random traffic
// compared against an arithmetic reference model.
module tb_shift_left;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] A;
   logic [31:0] B;
   logic        out_valid;
   logic [31:0] out;
`ifdef SHIFT_LEFT_OVF_EN
   logic        ovf;
`endif

   logic [31:0] exp_out;
   logic        exp_valid;
   logic        exp_ovf;
   int          total;
   int          bad;

   shift_left #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
`ifdef SHIFT_LEFT_OVF_EN
      .out       (out),
      .ovf       (ovf)
`else
      .out       (out)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: widen to 64 bits, shift, keep the low half; anything in the high half was lost.
   function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] wide;
      if (b >= 32) return 32'h0;
      wide = {32'h0, a} << b;
      return wide[31:0];
   endfunction

   function automatic logic ref_ovf(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] wide;
      if (b >= 32) return (a != 0);
      wide = {32'h0, a} << b;
      return (wide[63:32] != 0);
   endfunction

   task automatic applyStimulus(input logic rst, input logic v, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      rst_n    = rst;
      in_valid = v;
      A        = a;
      B        = b;
      @(posedge clk);
      if (!rst) begin
         exp_out   = 32'h0;
         exp_valid = 1'b0;
         exp_ovf   = 1'b0;
      end else if (v) begin
         exp_out   = ref_shift(a, b);
         exp_valid = 1'b1;
         exp_ovf   = ref_ovf(a, b);
      end else begin
         exp_valid = 1'b0;
      end
      #1;
   endtask

   task automatic checkOutput(input string tag);
      total++;
      assert (out_valid === exp_valid) else begin
         bad++;
         $error("[TB] FAIL %s out_valid got=%0b want=%0b", tag, out_valid, exp_valid);
      end
      total++;
      assert (out === exp_out) else begin
         bad++;
         $error("[TB] FAIL %s out got=%h want=%h", tag, out, exp_out);
      end
`ifdef SHIFT_LEFT_OVF_EN
      total++;
      assert (ovf === exp_ovf) else begin
         bad++;
         $error("[TB] FAIL %s ovf got=%0b want=%0b", tag, ovf, exp_ovf);
      end
`endif
   endtask

   task automatic checkConst(input string tag, input logic [31:0] want);
      total++;
      assert (out === want) else begin
         bad++;
         $error("[TB] FAIL %s out got=%h want=%h", tag, out, want);
      end
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rv;
      logic        rr;
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      A         = 32'h0;
      B         = 32'h0;
      exp_out   = 32'h0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;

      // Reset held with in_valid asserted: operands must be discarded.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 32'd1);
         checkOutput("reset_hold");
      end

      // First capture after release shows up exactly one edge later.
      applyStimulus(1'b1, 1'b1, 32'h0000_0005, 32'd3);
      checkOutput("first_after_reset");
      checkConst("first_after_reset_const", 32'h0000_0028);

      for (int b = 0; b <= 33; b++) begin
         applyStimulus(1'b1, 1'b1, 32'h0000_0002, 32'(b));
         checkOutput($sformatf("sweep_b%0d", b));
         if (b == 29) checkConst("sweep_b29_const", 32'h4000_0000);
         if (b == 30) checkConst("sweep_b30_const", 32'h8000_0000);
         if (b == 31) checkConst("sweep_b31_const", 32'h0000_0000);
      end

      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd4);
      checkOutput("ones_b4");
      checkConst("ones_b4_const", 32'hFFFF_FFF0);
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0100);
      checkOutput("ones_b256");
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      checkOutput("ones_bmax");

      applyStimulus(1'b1, 1'b1, 32'h0000_0001, 32'd31);
      checkOutput("one_b31");
      applyStimulus(1'b1, 1'b1, 32'h8000_0000, 32'd1);
      checkOutput("msb_b1");
      applyStimulus(1'b1, 1'b1, 32'h1234_5678, 32'd0);
      checkOutput("b_zero");
      checkConst("b_zero_const", 32'h1234_5678);

      // Valid pattern 1,0,1: out holds across the gap.
      applyStimulus(1'b1, 1'b1, 32'h0000_00A5, 32'd8);
      checkOutput("gap_first");
      applyStimulus(1'b1, 1'b0, 32'h0F0F_0F0F, 32'd2);
      checkOutput("gap_idle");
      checkConst("gap_idle_hold", 32'h0000_A500);
      applyStimulus(1'b1, 1'b1, 32'h0000_0003, 32'd12);
      checkOutput("gap_second");

      for (int i = 0; i < 300; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0: rb = $urandom;
            1: rb = 32'($urandom_range(28, 40));
            default: rb = 32'($urandom_range(0, 31));
         endcase
         rv = ($urandom_range(0, 3) != 0);
         rr = ($urandom_range(0, 31) != 0);
         applyStimulus(rr, rv, ra, rb);
         checkOutput($sformatf("rand_%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_left.md
SHIFT_LEFT -- requirements
Module: shift_left

Interface
REQ-001 Parameter WIDTH, default 32, data width of A and out; B is always 32 bits wide.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  qualifies A/B for capture this cycle.
REQ-005 A  input  WIDTH  operand to be shifted.
REQ-006 B  input  32  unsigned shift amount.
REQ-007 out_valid  output  1  out holds the result of a captured operation.
REQ-008 out  output  WIDTH  registered result.
REQ-009 ovf  output  1  a nonzero bit was shifted out; present only under SHIFT_LEFT_OVF_EN.

Function
REQ-010 The block SHALL compute the logical left shift of A by B; vacated LSBs are zero-filled, with no arithmetic or sign handling.
REQ-011 For B < WIDTH, out SHALL equal A << B, truncated to WIDTH bits.
REQ-012 For B >= WIDTH, including all B with any of bits [31:$clog2(WIDTH)] set, out SHALL be zero; the shift amount is never taken modulo WIDTH.
REQ-013 The shift SHALL be a log2(WIDTH)-stage barrel shifter; stage k shifts by 2^k when B[k] is set.
REQ-014 Latency SHALL be exactly 1 cycle: operands with in_valid=1 at edge N appear on out/out_valid after edge N.
REQ-015 With in_valid=0 at an edge, out_valid SHALL go 0 and out SHALL hold its previous value.
REQ-016 Back-to-back in_valid SHALL give one result per cycle; there is no backpressure or stall.
REQ-017 B=0 SHALL return A unchanged.

Reset
REQ-018 While rst_n=0 at a rising edge, out SHALL become 0, out_valid 0 and ovf 0.
REQ-019 Reset SHALL override a simultaneous in_valid=1; that operand is discarded.
REQ-020 The first in_valid=1 after rst_n returns high SHALL produce a valid result one cycle later.

Configuration
REQ-021 Macro SHIFT_LEFT_OVF_EN defined: port ovf exists and is registered with out.
- ovf=1 iff any set bit of A is lost, i.e. (B >= WIDTH and A != 0), or any of the top B bits of A is 1.
REQ-022 Macro undefined: the ovf port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-023 Package shift_left_pkg SHALL hold the constants DATA_W=32, SHAMT_W=32 and STAGES=$clog2(DATA_W).
REQ-024 One sub-module, shl_barrel_stage, SHALL be used:
- parameter SHIFT;
- conditional shift-by-constant of a WIDTH-bit vector, plus a lost-bits-nonzero flag;
- instantiated STAGES times in a generate loop.

Verification
REQ-025 A=0x00000002, B swept 0..33 with in_valid=1 each cycle:
- B=0..29: out=2<<B (B=29 -> 0x40000000);
- B=30: out=0x80000000;
- B=31..33: out=0x00000000.
REQ-026 A=0xFFFFFFFF, B=4 -> out=0xFFFFFFF0; B=0x100 -> out=0; B=0xFFFFFFFF -> out=0; ovf=1 in all three cases (macro defined).
REQ-027 A=0x00000001, B=31 -> out=0x80000000, ovf=0; then A=0x80000000, B=1 -> out=0, ovf=1.
REQ-028 Drive in_valid=1 with rst_n=0, then release reset:
- out=0 and out_valid=0 while reset is held;
- first valid result appears exactly one cycle after the first captured in_valid.
REQ-029 in_valid pattern 1,0,1 with distinct operands -> out_valid pattern 1,0,1 one cycle later; out holds its previous value during the gap.
